conv_rtm_rd: RTL and testbench

CONV_RTM_RD -- requirements
Module: conv_rtm_rd

---
 rtl/conv_rtm_rd_if.sv | 39 +++
 rtl/conv_rtm_rd.sv | 245 ++++++++++++++++++++++++
 tb/tb_conv_rtm_rd.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_rtm_rd_if.sv
// RTM read port plus the x stream towards the PE array.
// Lane count, lane bytes and RTM depth come from the `S, `R and `RTM_DEPTH macros.
`ifndef S
`define S 8
`endif
`ifndef R
`define R 2
`endif
`ifndef RTM_DEPTH
`define RTM_DEPTH 64
`endif

interface conv_rtm_rd_if;
    localparam int unsigned S_N    = `S;
    localparam int unsigned LANE_W = `R * 8;
    localparam int unsigned DW     = S_N * LANE_W;
    localparam int unsigned AW     = $clog2(`RTM_DEPTH);

    logic                rtm_rd_vld;
    logic [S_N-1:0]      rtm_rd_en;
    logic [S_N*AW-1:0]   rtm_rd_addr;
    logic [DW-1:0]       rtm_dout;
    logic [DW-1:0]       x_data;
    logic                x_vld;
    logic                x_last;
    logic                x_rdy;

    // Reader side: issues RTM reads and sources the x stream.
    modport master (
        output rtm_rd_vld, rtm_rd_en, rtm_rd_addr, x_data, x_vld, x_last,
        input  rtm_dout, x_rdy
    );

    // RTM and PE-array side.
    modport slave (
        input  rtm_rd_vld, rtm_rd_en, rtm_rd_addr, x_data, x_vld, x_last,
        output rtm_dout, x_rdy
    );
endinterface

// File: rtl/conv_rtm_rd.sv
// RTM reader for the conv engine: walks w/x/h loops, issues credit-limited
// fixed-latency RTM reads and streams the returned rows to the PE array.
// Optional: CONV_RTM_RD_ZERO_MASK_EN zeroes x_data lanes that were not read.
`ifndef S
`define S 8
`endif
`ifndef R
`define R 2
`endif
`ifndef RTM_DEPTH
`define RTM_DEPTH 64
`endif

module conv_rtm_rd #(
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned BUF_DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_pulse,
    output logic                           done_pulse,
    input  logic [$clog2(`RTM_DEPTH)-1:0]  X_addr,
    input  logic [15:0]                    n_W_rnd_minus_1,
    input  logic [15:0]                    n_X_rnd_minus_1,
    input  logic [15:0]                    ifm_height,
    input  logic [7:0]                     n_last_batch,
    conv_rtm_rd_if.master                  bus
);
    localparam int unsigned S_N    = `S;
    localparam int unsigned LANE_W = `R * 8;
    localparam int unsigned DW     = S_N * LANE_W;
    localparam int unsigned AW     = $clog2(`RTM_DEPTH);
    localparam int unsigned PW     = $clog2(BUF_DEPTH);
    localparam int unsigned CW     = PW + 1;
    localparam int unsigned SW     = CW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   xa_q, base_q, base_d, cur_xa, cur_base, iss_addr, rd_addr_q;
    logic [15:0]     nw_q, nx_q, ht_q, cur_nw, cur_nx, cur_ht;
    logic [15:0]     w_q, x_q, h_q, w_d, x_d, h_d;
    logic [7:0]      nlb_q, cur_nlb;
    logic [S_N-1:0]  lane_mask, iss_en, rd_en_q;
    logic            rd_vld_q, rd_last_q, iss, iss_last, done_q, done_d;
    logic            h_end, x_end, w_end, last_iss, credit_ok, drain_done;
    logic [RD_LAT-1:0] pv_q, pl_q;
    logic [CW-1:0]   out_q, occ_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic            push_c, pop_c, x_vld_c;

    logic [DW-1:0]   buf_data [BUF_DEPTH];
    logic            buf_last [BUF_DEPTH];

    assign push_c  = pv_q[RD_LAT-1];
    assign x_vld_c = (occ_q != '0);
    assign pop_c   = x_vld_c && bus.x_rdy;

    // Loop walk, credit check and FSM next state; IDLE uses the live inputs so the first read issues on start.
    always_comb begin
        state_d  = state_q;
        iss      = 1'b0;
        done_d   = 1'b0;
        w_d      = w_q;
        x_d      = x_q;
        h_d      = h_q;
        base_d   = base_q;
        lane_mask = '0;

        cur_xa   = (state_q == IDLE) ? X_addr          : xa_q;
        cur_base = (state_q == IDLE) ? X_addr          : base_q;
        cur_nw   = (state_q == IDLE) ? n_W_rnd_minus_1 : nw_q;
        cur_nx   = (state_q == IDLE) ? n_X_rnd_minus_1 : nx_q;
        cur_ht   = (state_q == IDLE) ? ifm_height      : ht_q;
        cur_nlb  = (state_q == IDLE) ? n_last_batch    : nlb_q;

        for (int i = 0; i < S_N; i++) begin
            lane_mask[i] = (8'(i) < cur_nlb);
        end

        h_end     = (h_q == cur_ht - 16'd1);
        x_end     = (x_q == cur_nx);
        w_end     = (w_q == cur_nw);
        last_iss  = h_end && x_end && w_end;
        credit_ok = (SW'(out_q) + SW'(occ_q)) < SW'(BUF_DEPTH);
        drain_done = (out_q == '0) &&
                     ((occ_q == '0) || ((occ_q == CW'(1)) && pop_c));

        iss_addr = cur_base + AW'(h_q);
        iss_en   = x_end ? lane_mask : '1;
        iss_last = h_end;

        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    if (ifm_height == 16'd0) begin
                        state_d = DRAIN;
                    end else begin
                        iss     = 1'b1;
                        state_d = last_iss ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    iss = 1'b1;
                    if (last_iss) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (iss) begin
            base_d = cur_base;
            if (last_iss) begin
                w_d = '0;
                x_d = '0;
                h_d = '0;
            end else if (h_end) begin
                h_d = '0;
                if (x_end) begin
                    x_d    = '0;
                    w_d    = w_q + 16'd1;
                    base_d = cur_xa;
                end else begin
                    x_d    = x_q + 16'd1;
                    base_d = cur_base + AW'(cur_ht);
                end
            end else begin
                h_d = h_q + 16'd1;
            end
        end
    end

    // State, instruction latch, counters, read request, latency pipe and buffer bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            xa_q      <= '0;
            nw_q      <= '0;
            nx_q      <= '0;
            ht_q      <= '0;
            nlb_q     <= '0;
            w_q       <= '0;
            x_q       <= '0;
            h_q       <= '0;
            base_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_en_q   <= '0;
            rd_addr_q <= '0;
            rd_last_q <= 1'b0;
            pv_q      <= '0;
            pl_q      <= '0;
            out_q     <= '0;
            occ_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_pulse) begin
                xa_q  <= X_addr;
                nw_q  <= n_W_rnd_minus_1;
                nx_q  <= n_X_rnd_minus_1;
                ht_q  <= ifm_height;
                nlb_q <= n_last_batch;
            end
            w_q       <= w_d;
            x_q       <= x_d;
            h_q       <= h_d;
            base_q    <= base_d;
            rd_vld_q  <= iss;
            rd_en_q   <= iss ? iss_en : '0;
            if (iss) begin
                rd_addr_q <= iss_addr;
                rd_last_q <= iss_last;
            end
            pv_q[0] <= rd_vld_q;
            pl_q[0] <= rd_last_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pl_q[k] <= pl_q[k-1];
            end
            out_q    <= out_q + CW'(iss) - CW'(push_c);
            occ_q    <= occ_q + CW'(push_c) - CW'(pop_c);
            if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
            done_q   <= done_d;
        end
    end

    // Output buffer storage; written RD_LAT cycles after each read request.
    always_ff @(posedge clk) begin
        if (push_c) begin
            buf_data[wr_ptr_q] <= bus.rtm_dout;
            buf_last[wr_ptr_q] <= pl_q[RD_LAT-1];
        end
    end

`ifdef CONV_RTM_RD_ZERO_MASK_EN
    logic [RD_LAT-1:0][S_N-1:0] pm_q;
    logic [S_N-1:0]             buf_mask [BUF_DEPTH];
    logic [DW-1:0]              head_data;
    logic [S_N-1:0]             head_mask;

    // Lane-enable pipe running alongside the valid pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q <= '0;
        end else begin
            pm_q[0] <= rd_en_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pm_q[k] <= pm_q[k-1];
            end
        end
    end

    // Per-entry lane mask stored next to the data.
    always_ff @(posedge clk) begin
        if (push_c) buf_mask[wr_ptr_q] <= pm_q[RD_LAT-1];
    end

    assign head_data = buf_data[rd_ptr_q];
    assign head_mask = buf_mask[rd_ptr_q];
    for (genvar l = 0; l < S_N; l++) begin : g_zero
        assign bus.x_data[l*LANE_W +: LANE_W] =
            head_mask[l] ? head_data[l*LANE_W +: LANE_W] : '0;
    end
`else
    assign bus.x_data = buf_data[rd_ptr_q];
`endif

    assign bus.rtm_rd_vld  = rd_vld_q;
    assign bus.rtm_rd_en   = rd_en_q;
    assign bus.rtm_rd_addr = {S_N{rd_addr_q}};
    assign bus.x_vld       = x_vld_c;
    assign bus.x_last      = x_vld_c && buf_last[rd_ptr_q];
    assign done_pulse      = done_q;
endmodule

// File: tb/tb_conv_rtm_rd.sv
// Directed bench for conv_rtm_rd with a fixed-latency RTM model.
`ifndef S
`define S 8
`endif
`ifndef R
`define R 2
`endif
`ifndef RTM_DEPTH
`define RTM_DEPTH 64
`endif

module tb_conv_rtm_rd;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned BUF_DEPTH = 32;
    localparam int unsigned S_N       = `S;
    localparam int unsigned LANE_W    = `R * 8;
    localparam int unsigned DW        = S_N * LANE_W;
    localparam int unsigned AW        = $clog2(`RTM_DEPTH);
    localparam int unsigned DEPTH     = `RTM_DEPTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_pulse;
    logic              done_pulse;
    logic [AW-1:0]     X_addr;
    logic [15:0]       n_W_rnd_minus_1, n_X_rnd_minus_1, ifm_height;
    logic [7:0]        n_last_batch;

    conv_rtm_rd_if rif ();

    conv_rtm_rd #(.RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_pulse     (start_pulse),
        .done_pulse      (done_pulse),
        .X_addr          (X_addr),
        .n_W_rnd_minus_1 (n_W_rnd_minus_1),
        .n_X_rnd_minus_1 (n_X_rnd_minus_1),
        .ifm_height      (ifm_height),
        .n_last_batch    (n_last_batch),
        .bus             (rif)
    );

    always #5 clk = ~clk;

    // RTM model: each lane's data is a fixed function of that lane's address.
    function automatic logic [DW-1:0] rtm_word(input logic [S_N*AW-1:0] a);
        logic [DW-1:0] w;
        logic [AW-1:0] la;
        w = '0;
        for (int l = 0; l < S_N; l++) begin
            la = a[l*AW +: AW];
            for (int b = 0; b < LANE_W/8; b++) begin
                w[l*LANE_W + b*8 +: 8] = 8'(32'(la) * 3 + l * 16 + b * 5 + 1);
            end
        end
        return w;
    endfunction

    logic [S_N*AW-1:0] apipe [RD_LAT];
    always @(posedge clk) begin
        apipe[0] <= rif.rtm_rd_addr;
        for (int k = 1; k < RD_LAT; k++) apipe[k] <= apipe[k-1];
    end
    always_comb rif.rtm_dout = rtm_word(apipe[RD_LAT-1]);

    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a, input logic [S_N-1:0] en);
        logic [DW-1:0] w;
        bit zero_mode;
`ifdef CONV_RTM_RD_ZERO_MASK_EN
        zero_mode = 1'b1;
`else
        zero_mode = 1'b0;
`endif
        w = rtm_word({S_N{a}});
        for (int l = 0; l < S_N; l++) begin
            if (zero_mode && !en[l]) w[l*LANE_W +: LANE_W] = '0;
        end
        return w;
    endfunction

    int checks = 0;
    int failures = 0;

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observed and expected traces of one instruction.
    logic [AW-1:0]  got_addr[$], exp_addr[$];
    logic [S_N-1:0] got_en[$],   exp_en[$];
    logic [DW-1:0]  got_data[$];
    logic           got_last[$], exp_last[$];
    int lat, done_cyc, last_beat, done_cnt, max_out, iss100, unstable, addr_bad;

    task automatic build_exp(input logic [AW-1:0] xa, input int nw, input int nx, input int ht, input int nlb);
        logic [S_N-1:0] m;
        exp_addr.delete(); exp_en.delete(); exp_last.delete();
        for (int l = 0; l < S_N; l++) m[l] = (l < nlb);
        for (int w = 0; w <= nw; w++)
            for (int x = 0; x <= nx; x++)
                for (int h = 0; h < ht; h++) begin
                    exp_addr.push_back(AW'((32'(xa) + x * ht + h) % DEPTH));
                    exp_en.push_back((x == nx) ? m : '1);
                    exp_last.push_back(h == ht - 1);
                end
    endtask

    task automatic run(input logic [AW-1:0] xa, input int nw, input int nx, input int ht,
                       input int nlb, input int mode, input bit restart);
        int k, issued, beats;
        bit fin, hold;
        logic [DW-1:0] pdata;
        logic plast;
        got_addr.delete(); got_en.delete(); got_data.delete(); got_last.delete();
        lat = -1; done_cyc = -1; last_beat = -1; done_cnt = 0; max_out = 0;
        iss100 = -1; unstable = 0; addr_bad = 0;
        issued = 0; beats = 0; k = 0; fin = 1'b0; hold = 1'b0;
        pdata = '0; plast = 1'b0;
        @(posedge clk); #1;
        X_addr = xa; n_W_rnd_minus_1 = 16'(nw); n_X_rnd_minus_1 = 16'(nx);
        ifm_height = 16'(ht); n_last_batch = 8'(nlb);
        start_pulse = 1'b1;
        rif.x_rdy = (mode != 1);
        while (!fin) begin
            @(posedge clk); #1;
            k++;
            start_pulse = restart && (k == 3);
            if (k == 1) begin
                X_addr = xa ^ AW'(5); ifm_height = 16'(ht + 3);
                n_X_rnd_minus_1 = 16'(nx + 1); n_last_batch = 8'd1;
            end
            case (mode)
                0: rif.x_rdy = 1'b1;
                1: rif.x_rdy = (k >= 100);
                default: rif.x_rdy = 1'($urandom_range(0, 1));
            endcase
            if (rif.rtm_rd_vld) begin
                got_addr.push_back(rif.rtm_rd_addr[AW-1:0]);
                got_en.push_back(rif.rtm_rd_en);
                if (rif.rtm_rd_addr !== {S_N{rif.rtm_rd_addr[AW-1:0]}}) addr_bad++;
                issued++;
            end
            if (rif.x_vld && lat < 0) lat = k;
            if (hold && (!rif.x_vld || rif.x_data !== pdata || rif.x_last !== plast)) unstable++;
            if (rif.x_vld && rif.x_rdy) begin
                got_data.push_back(rif.x_data);
                got_last.push_back(rif.x_last);
                beats++;
                last_beat = k;
            end
            hold  = rif.x_vld && !rif.x_rdy;
            pdata = rif.x_data;
            plast = rif.x_last;
            if (issued - beats > max_out) max_out = issued - beats;
            if (k == 99) iss100 = issued;
            if (done_pulse) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc >= 0 && k >= done_cyc + 5) fin = 1'b1;
            if (k >= 4000) fin = 1'b1;
        end
    endtask

    task automatic check_run(input string tag);
        int n;
        chk_int({tag, " n_reads"}, got_addr.size(), exp_addr.size());
        chk_int({tag, " n_beats"}, got_data.size(), exp_addr.size());
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk_int($sformatf("%s addr[%0d]", tag, i), int'(got_addr[i]), int'(exp_addr[i]));
            chk_int($sformatf("%s en[%0d]", tag, i), int'(got_en[i]), int'(exp_en[i]));
        end
        n = (got_data.size() < exp_addr.size()) ? got_data.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk_vec($sformatf("%s data[%0d]", tag, i), got_data[i], exp_word(exp_addr[i], exp_en[i]));
            chk_int($sformatf("%s last[%0d]", tag, i), int'(got_last[i]), int'(exp_last[i]));
        end
        chk_int({tag, " done_count"}, done_cnt, 1);
        chk_int({tag, " done_timing"}, done_cyc, last_beat + 1);
        chk_int({tag, " lane_addr_equal"}, addr_bad, 0);
        chk_int({tag, " data_stable"}, unstable, 0);
        chk_int({tag, " credit_bound"}, int'(max_out <= int'(BUF_DEPTH)), 1);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start_pulse = 1'b0; X_addr = '0;
        n_W_rnd_minus_1 = '0; n_X_rnd_minus_1 = '0; ifm_height = '0; n_last_batch = '0;
        rif.x_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_int("rst rd_vld", int'(rif.rtm_rd_vld), 0);
        chk_int("rst rd_en", int'(rif.rtm_rd_en), 0);
        chk_int("rst x_vld", int'(rif.x_vld), 0);
        chk_int("rst x_last", int'(rif.x_last), 0);
        chk_int("rst done", int'(done_pulse), 0);
        rst_n = 1'b1;

        // Two x rounds of three rows, full throughput.
        build_exp(AW'(10), 0, 1, 3, S_N);
        run(AW'(10), 0, 1, 3, S_N, 0, 1'b0);
        check_run("basic");
        chk_int("basic latency", lat, RD_LAT + 2);

        // Three w rounds over the same rows.
        build_exp(AW'(5), 2, 0, 4, S_N);
        run(AW'(5), 2, 0, 4, S_N, 0, 1'b0);
        check_run("w_loop");

        // Partial last batch: only lanes 0..2 enabled in the last round.
        build_exp(AW'(20), 0, 1, 2, 3);
        run(AW'(20), 0, 1, 2, 3, 0, 1'b0);
        check_run("last_batch");

        // Consumer stalled for 100 cycles: issue stops at the credit limit.
        build_exp(AW'(0), 0, 3, 16, S_N);
        run(AW'(0), 0, 3, 16, S_N, 1, 1'b0);
        check_run("backpressure");
        chk_int("backpressure reads_while_stalled", iss100, BUF_DEPTH);

        // Random ready pattern.
        build_exp(AW'(40), 1, 2, 3, 5);
        run(AW'(40), 1, 2, 3, 5, 2, 1'b0);
        check_run("random_rdy");

        // A second start mid-run must be ignored.
        build_exp(AW'(30), 1, 0, 5, S_N);
        run(AW'(30), 1, 0, 5, S_N, 0, 1'b1);
        check_run("restart_ignored");

        // Empty instruction.
        run(AW'(7), 0, 0, 0, S_N, 0, 1'b0);
        chk_int("empty n_reads", got_addr.size(), 0);
        chk_int("empty n_beats", got_data.size(), 0);
        chk_int("empty done_cycle", done_cyc, 2);
        chk_int("empty done_count", done_cnt, 1);

        // Reset in the middle of a long instruction.
        @(posedge clk); #1;
        X_addr = AW'(3); n_W_rnd_minus_1 = 16'd0; n_X_rnd_minus_1 = 16'd3;
        ifm_height = 16'd16; n_last_batch = 8'(S_N); rif.x_rdy = 1'b1;
        start_pulse = 1'b1;
        @(posedge clk); #1;
        start_pulse = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_int("midrst rd_vld", int'(rif.rtm_rd_vld), 0);
        chk_int("midrst rd_en", int'(rif.rtm_rd_en), 0);
        chk_int("midrst x_vld", int'(rif.x_vld), 0);
        chk_int("midrst x_last", int'(rif.x_last), 0);
        chk_int("midrst done", int'(done_pulse), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rif.x_vld || rif.rtm_rd_vld || done_pulse) bad++;
        end
        chk_int("midrst quiet_after", bad, 0);

        // Address wrap past the top of RTM, right after the reset.
        build_exp(AW'(DEPTH - 2), 0, 0, 4, S_N);
        run(AW'(DEPTH - 2), 0, 0, 4, S_N, 0, 1'b0);
        check_run("wrap");
        chk_int("wrap addr2", (got_addr.size() > 2) ? int'(got_addr[2]) : -1, 0);
        chk_int("wrap addr3", (got_addr.size() > 3) ? int'(got_addr[3]) : -1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
